dgldpc_vnu_scheduler: RTL and testbench
=======================================

Name: dgldpc_vnu_scheduler

Overview:
- Sequences one shared, purely combinational shuffled VNU across N_VN variable nodes for up to a programmable number of decoding iterations.
- Per node: reads the channel LLR and 4 check-to-variable messages from node memory, presents them to the VNU, and captures its 5 outputs (4 V2C, 1 APP). It then writes them back and tracks hard decisions.
- Stops on iteration limit or hard-decision convergence, and reports done, iteration count and convergence to the decoder top level.

Parameters:
- N_VN, 16, number of variable nodes per codeword (≥2).
- ADDR_W, 4, node address width; must satisfy 2**ADDR_W ≥ N_VN.
- ITER_W, 5, width of iteration limit and iteration counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_abort  in  1  abandon current codeword; no o_done is produced.
- i_n_iter  in  ITER_W  max iterations, sampled at accepted start; 0 is treated as 1.
- o_busy  out  1  high from cycle after accepted start until cycle after o_done or abort.
- o_done  out  1  one-cycle pulse at end of decode.
- o_converged  out  1  valid with o_done and held until next start: 1 = stopped by convergence.
- o_iter_used  out  ITER_W  completed iterations; valid with o_done and held until next start.
- o_hd_vec  out  N_VN  hard decisions, bit k = node k; held until next start.
- o_rd_en  out  1  memory read strobe.
- o_rd_addr  out  ADDR_W  node address to read.
- i_llr  in  8  two's-complement channel LLR, valid exactly 1 cycle after o_rd_en.
- i_c2v  in  4x6  sign-magnitude C2V messages, valid with i_llr.
- o_vnu_llr  out  8  registered LLR to the VNU.
- o_vnu_data  out  4x6  registered C2V messages to the VNU.
- i_vnu_data  in  5x9  VNU outputs, sign-magnitude: [0..3] V2C, [4] APP; combinational from o_vnu_*.
- o_wr_en  out  1  write-back strobe.
- o_wr_addr  out  ADDR_W  write-back node address.
- o_v2c  out  4x9  registered V2C messages.
- o_app  out  9  registered APP.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; iteration counter 0; pipeline valids 0; internal HD store 0.
- FSM states are IDLE, SWEEP, DRAIN, CHECK, FIN.
- IDLE: on i_start=1, latch max(i_n_iter,1), clear iteration counter, clear o_converged/o_iter_used/o_hd_vec; go to SWEEP. o_busy rises the next cycle.
- SWEEP: o_rd_en=1 every cycle with o_rd_addr = 0,1,…,N_VN-1, one per cycle, no gaps. After address N_VN-1 is issued, go to DRAIN.
- Pipeline (3 cycles, read issue to write):
  - Stage 1, cycle t+1: memory data is registered into o_vnu_llr/o_vnu_data together with the address and a valid bit.
  - Stage 2, cycle t+2: i_vnu_data is registered into o_v2c/o_app.
  - Stage 3, cycle t+3: o_wr_en=1 and o_wr_addr = t's address.
- Throughput is 1 node/cycle. o_vnu_* hold their last value when stage-1 valid is 0.
- Hard decisions: at stage 2 capture, hd = i_vnu_data[4][8] (sign bit; 1 = negative). Write it into HD store[addr]. If it differs from the stored bit, set the sweep-changed flag. The flag is cleared on entry to SWEEP.
- DRAIN: wait until all pipeline valids are 0 (exactly 3 cycles after last read), then go to CHECK.
- CHECK (1 cycle): increment iteration counter.
  - If changed=0 and counter ≥2 → converged=1, go to FIN.
  - Else if counter = limit → converged=0, go to FIN.
  - Else go to SWEEP.
- Convergence is never declared on iteration 1.
- FIN: o_done=1 for one cycle; o_iter_used=counter; o_hd_vec=HD store; go to IDLE.
- i_abort in any non-IDLE state: next cycle FSM is IDLE, all pipeline valids are 0, o_rd_en/o_wr_en/o_busy are 0, and no o_done is produced. Results outputs are not updated.
- rst mid-operation behaves identically to abort, plus full output reset.
- i_start while not IDLE is ignored. i_start and i_abort together in IDLE: abort wins, start is ignored.
- Consecutive iterations are not overlapped: the next SWEEP starts only after write-back of node N_VN-1. This preserves shuffled read-after-write ordering.

Test Plan:
- N_VN=4, i_n_iter=2, stub VNU returns APP sign alternating per iteration → reads addr 0..3 on cycles 1..4 after start, o_wr_en on cycles 4..7 with addr 0..3; o_done with o_iter_used=2, o_converged=0.
- Stub APP=9'h005 (positive) for all nodes every iteration, i_n_iter=10 → iteration 1 sets changed flag? No, stored 0 = positive, so nothing changes, but convergence is blocked on iteration 1; done after iteration 2 with o_converged=1, o_iter_used=2, o_hd_vec=4'b0000.
- APP=9'h105 for node 2 only, constant, i_n_iter=5 → o_hd_vec=4'b0100, converged=1, o_iter_used=2.
- i_n_iter=0 → exactly one sweep; o_iter_used=1, o_converged=0.
- i_abort asserted 2 cycles into the second sweep → next cycle o_busy=0, o_wr_en=0, no o_done. A new start then gives a normal full result.
- i_start pulsed during SWEEP, and rst asserted mid-DRAIN → start ignored (single o_done); after rst, all outputs are 0 and IDLE accepts a new start.

Source files
------------

// File: rtl/dgldpc_vnu_scheduler_if.sv
// dgldpc_vnu_scheduler_if: node-memory read, shared-VNU and write-back buses
// between the scheduler (master) and the memory/VNU datapath (slave).
interface dgldpc_vnu_scheduler_if #(parameter int ADDR_W = 4);
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [7:0]        i_llr;
    logic [3:0][5:0]   i_c2v;
    logic [7:0]        o_vnu_llr;
    logic [3:0][5:0]   o_vnu_data;
    logic [4:0][8:0]   i_vnu_data;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [3:0][8:0]   o_v2c;
    logic [8:0]        o_app;
    modport master (
        output o_rd_en, o_rd_addr, o_vnu_llr, o_vnu_data, o_wr_en, o_wr_addr, o_v2c, o_app,
        input  i_llr, i_c2v, i_vnu_data
    );
    modport slave (
        input  o_rd_en, o_rd_addr, o_vnu_llr, o_vnu_data, o_wr_en, o_wr_addr, o_v2c, o_app,
        output i_llr, i_c2v, i_vnu_data
    );
endinterface

// File: rtl/dgldpc_vnu_scheduler.sv
// dgldpc_vnu_scheduler: sweeps one shared combinational VNU over all variable nodes
// per iteration, tracks hard decisions and stops on iteration limit or convergence.
module dgldpc_vnu_scheduler #(
    parameter int N_VN   = 16,
    parameter int ADDR_W = 4,
    parameter int ITER_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ITER_W-1:0] i_n_iter,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_converged,
    output logic [ITER_W-1:0] o_iter_used,
    output logic [N_VN-1:0]   o_hd_vec,
    dgldpc_vnu_scheduler_if.master bus
);
    typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, CHECK, FIN} state_t;
    state_t            r_state, w_next;
    logic [ITER_W-1:0] r_limit, r_iter, w_iter_inc;
    logic [ADDR_W-1:0] r_addr, r_a0, r_a1;
    logic              r_v0, r_v1, r_changed;
    logic [N_VN-1:0]   r_hd;
    logic              w_hd, w_last, w_conv, w_stop;

    assign w_iter_inc = r_iter + 1'b1;
    assign w_last     = r_addr == ADDR_W'(N_VN - 1);
    assign w_hd       = bus.i_vnu_data[4][8];
    assign w_conv     = !r_changed && w_iter_inc >= ITER_W'(2);
    assign w_stop     = w_conv || w_iter_inc == r_limit;

    always_comb begin
        w_next        = r_state;
        o_busy        = r_state != IDLE;
        o_done        = r_state == FIN;
        bus.o_rd_en   = r_state == SWEEP;
        bus.o_rd_addr = r_addr;
        unique case (r_state)
            IDLE:    w_next = i_start ? SWEEP : IDLE;
            SWEEP:   w_next = w_last ? DRAIN : SWEEP;
            DRAIN:   w_next = (r_v0 || r_v1 || bus.o_wr_en) ? DRAIN : CHECK;
            CHECK:   w_next = w_stop ? FIN : SWEEP;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (i_abort) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_limit        <= '0;
            r_iter         <= '0;
            r_addr         <= '0;
            r_a0           <= '0;
            r_a1           <= '0;
            r_v0           <= 1'b0;
            r_v1           <= 1'b0;
            r_changed      <= 1'b0;
            r_hd           <= '0;
            o_converged    <= 1'b0;
            o_iter_used    <= '0;
            o_hd_vec       <= '0;
            bus.o_vnu_llr  <= '0;
            bus.o_vnu_data <= '0;
            bus.o_wr_en    <= 1'b0;
            bus.o_wr_addr  <= '0;
            bus.o_v2c      <= '0;
            bus.o_app      <= '0;
        end else begin
            r_state     <= w_next;
            r_v0        <= bus.o_rd_en && !i_abort;
            r_a0        <= r_addr;
            r_v1        <= r_v0 && !i_abort;
            r_a1        <= r_a0;
            bus.o_wr_en <= r_v1 && !i_abort;
            if (r_v0) begin
                bus.o_vnu_llr  <= bus.i_llr;
                bus.o_vnu_data <= bus.i_c2v;
            end
            // Stage 2: capture VNU result and fold the APP sign into the HD store
            if (r_v1) begin
                bus.o_v2c     <= bus.i_vnu_data[3:0];
                bus.o_app     <= bus.i_vnu_data[4];
                bus.o_wr_addr <= r_a1;
                r_hd[r_a1]    <= w_hd;
                if (w_hd != r_hd[r_a1]) r_changed <= 1'b1;
            end
            if (r_state == SWEEP) r_addr <= w_last ? '0 : r_addr + 1'b1;
            if (r_state != SWEEP && w_next == SWEEP) r_changed <= 1'b0;
            if (r_state == IDLE && w_next == SWEEP) begin
                r_limit     <= (i_n_iter == '0) ? ITER_W'(1) : i_n_iter;
                r_iter      <= '0;
                r_addr      <= '0;
                o_converged <= 1'b0;
                o_iter_used <= '0;
                o_hd_vec    <= '0;
            end
            if (r_state == CHECK && !i_abort) begin
                r_iter <= w_iter_inc;
                if (w_stop) begin
                    o_converged <= w_conv;
                    o_iter_used <= w_iter_inc;
                    o_hd_vec    <= r_hd;
                end
            end
        end
    end
endmodule

// File: tb/tb_dgldpc_vnu_scheduler.sv
// tb_dgldpc_vnu_scheduler: directed and randomized decodes against a per-sweep
// hard-decision model, with stub node memory and stub VNU.
module tb_dgldpc_vnu_scheduler;
    localparam int N = 4;
    logic       clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_abort = 1'b0;
    logic [4:0] i_n_iter = '0;
    logic       o_busy, o_done, o_converged;
    logic [4:0] o_iter_used;
    logic [N-1:0] o_hd_vec;
    int errors = 0, checks = 0, done_cnt = 0;

    dgldpc_vnu_scheduler_if #(.ADDR_W(2)) bus ();
    dgldpc_vnu_scheduler #(.N_VN(N), .ADDR_W(2), .ITER_W(5)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_n_iter(i_n_iter),
        .o_busy(o_busy), .o_done(o_done), .o_converged(o_converged),
        .o_iter_used(o_iter_used), .o_hd_vec(o_hd_vec), .bus(bus)
    );

    always #5 clk = ~clk;

    // P[tag] = APP sign pattern the stub VNU produces on the sweep carrying that tag
    logic [N-1:0] P [16];
    logic [3:0] rsweep = '0, mem_s = '0;
    logic [1:0] mem_a = '0;

    function automatic logic [7:0] llr_fn(logic [3:0] t, logic [1:0] a);
        return {t, 2'b00, a};
    endfunction
    function automatic logic [5:0] c2v_fn(logic [3:0] t, logic [1:0] a, int k);
        return 6'(int'(a) * 7 + k * 3 + int'(t));
    endfunction

    always @(posedge clk) begin
        if (bus.o_rd_en && bus.o_rd_addr == 2'd0) rsweep <= rsweep + 4'd1;
        mem_s <= (bus.o_rd_en && bus.o_rd_addr == 2'd0) ? rsweep + 4'd1 : rsweep;
        mem_a <= bus.o_rd_addr;
    end

    always_comb begin
        bus.i_llr = llr_fn(mem_s, mem_a);
        for (int k = 0; k < 4; k++) bus.i_c2v[k] = c2v_fn(mem_s, mem_a, k);
        for (int k = 0; k < 4; k++) bus.i_vnu_data[k] = 9'(bus.o_vnu_data[k]) ^ 9'h0A5;
        bus.i_vnu_data[4] = {P[bus.o_vnu_llr[7:4]][bus.o_vnu_llr[1:0]], bus.o_vnu_llr + 8'd3};
    end

    typedef struct packed {logic en; logic [1:0] a; logic [3:0] t;} ent_t;
    ent_t h [3];
    logic [1:0] rd_next = '0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // One clock: reads must reappear as write-backs exactly 3 cycles later unless killed
    task automatic tick();
        logic kill;
        kill = i_abort || rst;
        @(negedge clk);
        if (kill) for (int i = 0; i < 3; i++) h[i] = '0;
        chk("wr_en", bus.o_wr_en, h[2].en);
        if (h[2].en) begin
            chk("wr_addr", bus.o_wr_addr, h[2].a);
            chk("wr_app", bus.o_app, {P[h[2].t][h[2].a], llr_fn(h[2].t, h[2].a) + 8'd3});
            for (int k = 0; k < 4; k++)
                chk("wr_v2c", bus.o_v2c[k], 9'(c2v_fn(h[2].t, h[2].a, k)) ^ 9'h0A5);
        end
        h[2] = h[1];
        h[1] = h[0];
        h[0].en = bus.o_rd_en;
        h[0].a  = bus.o_rd_addr;
        h[0].t  = (bus.o_rd_addr == 2'd0) ? rsweep + 4'd1 : rsweep;
        if (bus.o_rd_en) begin
            chk("rd_addr", bus.o_rd_addr, rd_next);
            rd_next = rd_next + 2'd1;
        end
        if (o_done) done_cnt++;
    endtask

    task automatic fill(input int mode, input logic [N-1:0] pat);
        logic [N-1:0] p;
        p = pat;
        for (int s = 1; s < 16; s++) begin
            if (mode == 0) P[4'(rsweep + 4'(s))] = pat;
            else if (mode == 1) P[4'(rsweep + 4'(s))] = (s % 2 == 1) ? pat : ~pat;
            else begin
                p = ($urandom_range(2) == 0) ? p : N'($urandom);
                P[4'(rsweep + 4'(s))] = p;
            end
        end
    endtask

    task automatic model(input logic [4:0] n, input logic [3:0] b,
                         output logic [4:0] it, output logic cv, output logic [N-1:0] hv);
        int lim;
        logic [N-1:0] prv, cur;
        lim = (n == 0) ? 1 : int'(n);
        cv = 1'b0; prv = '0; it = '0; hv = '0;
        for (int i = 1; i <= lim; i++) begin
            cur = P[4'(b + 4'(i))];
            it = 5'(i);
            hv = cur;
            if (i >= 2 && cur == prv) begin
                cv = 1'b1;
                break;
            end
            prv = cur;
        end
    endtask

    task automatic start_run(input logic [4:0] n, output logic [3:0] b);
        chk("idle_busy", o_busy, 1'b0);
        b = rsweep;
        rd_next = '0;
        i_n_iter = n;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("busy_rise", o_busy, 1'b1);
        chk("rd_first", bus.o_rd_en, 1'b1);
        chk("clr_iter", o_iter_used, 5'd0);
        chk("clr_conv", o_converged, 1'b0);
        chk("clr_hd", o_hd_vec, 4'd0);
    endtask

    task automatic finish_run(input string nm, input logic [4:0] n, input logic [3:0] b);
        logic seen;
        logic [4:0] it;
        logic cv;
        logic [N-1:0] hv;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            seen = o_done;
        end
        chk({nm, "_done_seen"}, seen, 1'b1);
        model(n, b, it, cv, hv);
        chk({nm, "_iter"}, o_iter_used, it);
        chk({nm, "_conv"}, o_converged, cv);
        chk({nm, "_hd"}, o_hd_vec, hv);
        tick();
        chk({nm, "_done_pulse"}, o_done, 1'b0);
        chk({nm, "_busy_fall"}, o_busy, 1'b0);
        chk({nm, "_hold_iter"}, o_iter_used, it);
    endtask

    initial begin
        logic [3:0] b;
        logic found;
        int d0;
        for (int i = 0; i < 16; i++) P[i] = '0;
        for (int i = 0; i < 3; i++) h[i] = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_conv", o_converged, 1'b0);
        chk("rst_iter", o_iter_used, 5'd0);
        chk("rst_hd", o_hd_vec, 4'd0);
        chk("rst_rd", bus.o_rd_en, 1'b0);
        chk("rst_app", bus.o_app, 9'd0);
        // Alternating signs, limit 2
        fill(1, 4'b1010); start_run(5'd2, b); finish_run("alt", 5'd2, b);
        // All positive, limit 10: converges on iteration 2
        fill(0, 4'b0000); start_run(5'd10, b); finish_run("pos", 5'd10, b);
        // Node 2 negative only
        fill(0, 4'b0100); start_run(5'd5, b); finish_run("node2", 5'd5, b);
        // Limit 0 behaves as 1
        fill(1, 4'b0110); start_run(5'd0, b); finish_run("lim0", 5'd0, b);
        // Abort two cycles into the second sweep
        fill(1, 4'b1100); start_run(5'd5, b);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            found = bus.o_rd_en && bus.o_rd_addr == 2'd0;
        end
        chk("abort_sweep2_seen", found, 1'b1);
        tick();
        tick();
        d0 = done_cnt;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_busy", o_busy, 1'b0);
        chk("abort_wr", bus.o_wr_en, 1'b0);
        chk("abort_rd", bus.o_rd_en, 1'b0);
        for (int i = 0; i < 30; i++) tick();
        chk("abort_no_done", done_cnt, d0);
        chk("abort_iter_kept", o_iter_used, 5'd0);
        fill(2, 4'b0011); start_run(5'd4, b); finish_run("post_abort", 5'd4, b);
        // Start and abort together in IDLE: abort wins
        i_abort = 1'b1; i_start = 1'b1;
        tick();
        i_abort = 1'b0; i_start = 1'b0;
        chk("start_abort_idle", o_busy, 1'b0);
        // Start pulsed mid-sweep is ignored
        d0 = done_cnt;
        fill(1, 4'b1001); start_run(5'd3, b);
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        finish_run("start_ign", 5'd3, b);
        for (int i = 0; i < 40; i++) tick();
        chk("single_done", done_cnt, d0 + 1);
        // rst during DRAIN
        fill(0, 4'b1111); start_run(5'd3, b);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = bus.o_rd_en && bus.o_rd_addr == 2'd3;
        end
        chk("rst_last_rd_seen", found, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", o_busy, 1'b0);
        chk("mrst_wr", bus.o_wr_en, 1'b0);
        chk("mrst_rd", bus.o_rd_en, 1'b0);
        chk("mrst_vnu", {bus.o_vnu_llr, bus.o_vnu_data}, 32'd0);
        chk("mrst_v2c", {bus.o_v2c, bus.o_app}, 45'd0);
        chk("mrst_res", {o_converged, o_iter_used, o_hd_vec}, 10'd0);
        fill(1, 4'b0101); start_run(5'd2, b); finish_run("post_rst", 5'd2, b);
        // Randomized decodes
        for (int r = 0; r < 8; r++) begin
            logic [4:0] n;
            n = 5'($urandom_range(7));
            fill(2, N'($urandom));
            start_run(n, b);
            finish_run("rand", n, b);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
